// File: rtl/lfsr_if.sv
// ---------------------------------------------------------------------------
// lfsr_if -- output bundle of the lfsr pseudo-random generator.
//
// The generator has no handshake. The bundle only carries the current
// register word to its consumers.
//
// Parameters
//   N      word width (2..16), must match the N of the attached lfsr
//
// Signals
//   out    [N-1:0]  current LFSR state
//
// Modports
//   master  the lfsr itself (drives out)
//   slave   any consumer (reads out)
// ---------------------------------------------------------------------------
interface lfsr_if #(
   parameter int N = 3
);
   logic [N-1:0] out;

   modport master (output out);
   modport slave  (input  out);
endinterface

// File: rtl/lfsr.sv
// ---------------------------------------------------------------------------
// lfsr -- free-running Fibonacci linear-feedback shift register.
//
// Produces a new pseudo-random N-bit word on every rising clock edge. There
// is no enable. The register advances on every edge while reset is low. Each
// advance shifts the state left by one, and the feedback bit enters at bit 0.
// The feedback bit is the XOR of the maximal-length tap set for width N, so
// the period is 2^N-1 and the all-zero word is never produced.
//
// Optional build macro
//   LFSR_DEBRUIJN_EN  de Bruijn mode. The all-zero state is spliced into the
//                     sequence after 100..0, which gives a period of exactly
//                     2^N. A zero SEED is loaded as-is. Lock-up recovery is
//                     dropped because zero is an ordinary state in this mode.
//
// Parameters
//   N      register/output width, legal range 2..16
//   SEED   reset load value; only SEED[N-1:0] is used
//
// Ports
//   clk    system clock, rising edge
//   reset  synchronous, active-high; reloads the seed on the edge it is seen
//   bus    lfsr_if.master; bus.out is the state register itself. No
//          combinational path runs from any input to bus.out.
//
// Instances that share reset and SEED produce identical streams. Use
// distinct SEED values where independent streams are needed.
// ---------------------------------------------------------------------------
module lfsr #(
   parameter int          N    = 3,
   parameter int unsigned SEED = 1
) (
   input  logic   clk,
   input  logic   reset,
   lfsr_if.master bus
);

   if (N < 2 || N > 16) begin : g_bad_width
      $error("lfsr: N=%0d is outside the legal range 2..16", N);
   end

   // Maximal-length tap sets, held as 16-bit masks. Bit t-1 is set for
   // tap t (taps are 1-indexed).
   function automatic logic [15:0] tap_mask16(input int width);
      case (width)
         2:       tap_mask16 = 16'h0003;   // 2,1
         3:       tap_mask16 = 16'h0006;   // 3,2
         4:       tap_mask16 = 16'h000C;   // 4,3
         5:       tap_mask16 = 16'h0014;   // 5,3
         6:       tap_mask16 = 16'h0030;   // 6,5
         7:       tap_mask16 = 16'h0060;   // 7,6
         8:       tap_mask16 = 16'h00B8;   // 8,6,5,4
         9:       tap_mask16 = 16'h0110;   // 9,5
         10:      tap_mask16 = 16'h0240;   // 10,7
         11:      tap_mask16 = 16'h0500;   // 11,9
         12:      tap_mask16 = 16'h0829;   // 12,6,4,1
         13:      tap_mask16 = 16'h100D;   // 13,4,3,1
         14:      tap_mask16 = 16'h2015;   // 14,5,3,1
         15:      tap_mask16 = 16'h6000;   // 15,14
         16:      tap_mask16 = 16'hD008;   // 16,15,13,4
         default: tap_mask16 = 16'h0000;
      endcase
   endfunction

   localparam logic [15:0]  TAPS16 = tap_mask16(N);
   localparam logic [N-1:0] TAPS   = TAPS16[N-1:0];
   localparam logic [N-1:0] SEED_N = SEED[N-1:0];
   localparam logic [N-1:0] ONE    = {{(N-1){1'b0}}, 1'b1};

`ifdef LFSR_DEBRUIJN_EN
   localparam logic [N-1:0] RESET_VAL = SEED_N;
`else
   // A zero seed would park a standard LFSR in lock-up, so it is replaced by 1.
   localparam logic [N-1:0] RESET_VAL = (SEED_N == '0) ? ONE : SEED_N;
`endif

   logic [N-1:0] state;
   logic [N-1:0] state_next;
   logic         fb;

   always_comb begin
      fb = ^(state & TAPS);
`ifdef LFSR_DEBRUIJN_EN
      // When every bit below the MSB is zero, the feedback is inverted. This
      // turns 100..0 -> 000..0 and 000..0 -> 000..1, which splices zero
      // into the cycle.
      fb         = fb ^ (state[N-2:0] == '0);
      state_next = {state[N-2:0], fb};
`else
      state_next = {state[N-2:0], fb};
      // Zero is unreachable from any valid state. This recovery only fires
      // if the register was forced there; it restarts the generator at 1.
      if (state == '0) begin
         state_next = ONE;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RESET_VAL;
      end else begin
         state <= state_next;
      end
   end

   assign bus.out = state;

endmodule

// File: tb/tb_lfsr.sv
// ---------------------------------------------------------------------------
// tb_lfsr -- self-checking bench for lfsr.
//
// Instances: one per width 2..16 with SEED=1, plus N=3/SEED=5, N=4/SEED=0
// and N=4/SEED=8'hA5. All instances share one reset. The reference model
// works on plain integers and is built from the tap lists and the seed/
// lock-up rules. The sequence table covers N=3 reset, wrap and mid-run reset.
// A full-period sweep measures distinct values, zero occurrences and the
// return distance for each width.
// ---------------------------------------------------------------------------
module tb_lfsr;

   localparam int NI = 18;   // 15 SEED=1 widths + 3 extra instances

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [15:0] dut_out [NI];

   always #5 clk = ~clk;

   for (genvar g = 2; g <= 16; g++) begin : g_w
      lfsr_if #(.N(g)) bus ();
      lfsr #(.N(g), .SEED(1)) dut (.clk(clk), .reset(reset), .bus(bus));
      assign dut_out[g-2] = 16'(bus.out);
   end

   lfsr_if #(.N(3)) bus_3s5 ();
   lfsr #(.N(3), .SEED(5)) dut_3s5 (.clk(clk), .reset(reset), .bus(bus_3s5));
   assign dut_out[15] = 16'(bus_3s5.out);

   lfsr_if #(.N(4)) bus_4s0 ();
   lfsr #(.N(4), .SEED(0)) dut_4s0 (.clk(clk), .reset(reset), .bus(bus_4s0));
   assign dut_out[16] = 16'(bus_4s0.out);

   lfsr_if #(.N(4)) bus_4a5 ();
   lfsr #(.N(4), .SEED('hA5)) dut_4a5 (.clk(clk), .reset(reset), .bus(bus_4a5));
   assign dut_out[17] = 16'(bus_4a5.out);

   int passed = 0;
   int total  = 0;

   int unsigned m_n    [NI];
   int unsigned m_seed [NI];
   int unsigned m_st   [NI];

   typedef struct {
      logic       rst;
      logic [2:0] exp;
   } vec_t;
   vec_t tbl [$];

   bit seen [15][65536];
   int unsigned start_v   [15];
   int unsigned distinct  [15];
   int unsigned zeros     [15];
   int unsigned first_ret [15];

   // ---------------- reference model ----------------
   function automatic int unsigned period_of(input int n);
`ifdef LFSR_DEBRUIJN_EN
      return 1 << n;
`else
      return (1 << n) - 1;
`endif
   endfunction

   function automatic int unsigned ref_seed(input int n, input int unsigned seed);
      int unsigned v;
      v = seed % (1 << n);
`ifndef LFSR_DEBRUIJN_EN
      if (v == 0) v = 1;
`endif
      return v;
   endfunction

   function automatic int unsigned ref_next(input int n, input int unsigned s);
      int taps [$];
      int unsigned fb;
      case (n)
         2:  taps = {2, 1};
         3:  taps = {3, 2};
         4:  taps = {4, 3};
         5:  taps = {5, 3};
         6:  taps = {6, 5};
         7:  taps = {7, 6};
         8:  taps = {8, 6, 5, 4};
         9:  taps = {9, 5};
         10: taps = {10, 7};
         11: taps = {11, 9};
         12: taps = {12, 6, 4, 1};
         13: taps = {13, 4, 3, 1};
         14: taps = {14, 5, 3, 1};
         15: taps = {15, 14};
         16: taps = {16, 15, 13, 4};
         default: taps = {};
      endcase
      fb = 0;
      foreach (taps[i]) fb = fb ^ ((s / (1 << (taps[i] - 1))) % 2);
`ifdef LFSR_DEBRUIJN_EN
      if (s % (1 << (n - 1)) == 0) fb = fb ^ 1;
`else
      if (s == 0) return 1;
`endif
      return (s * 2 + fb) % (1 << n);
   endfunction

   // ---------------- helpers ----------------
   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // One clock. The model advances alongside the DUT and, when cmp is set,
   // every instance is compared against it.
   task automatic step(input logic r, input bit cmp);
      reset = r;
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         m_st[i] = r ? ref_seed(int'(m_n[i]), m_seed[i]) : ref_next(int'(m_n[i]), m_st[i]);
         if (cmp) check($sformatf("model inst%0d N=%0d", i, m_n[i]), dut_out[i], m_st[i]);
      end
   endtask

   initial begin
      for (int i = 0; i < 15; i++) begin
         m_n[i] = i + 2;
         m_seed[i] = 1;
      end
      m_n[15] = 3; m_seed[15] = 5;
      m_n[16] = 4; m_seed[16] = 0;
      m_n[17] = 4; m_seed[17] = 'hA5;
      for (int i = 0; i < NI; i++) m_st[i] = 0;

      // N=3 SEED=1: two-cycle reset, full wrap, then mid-run reset.
      tbl.push_back('{1'b1, 3'b001});
      tbl.push_back('{1'b1, 3'b001});
      tbl.push_back('{1'b0, 3'b010});
      tbl.push_back('{1'b0, 3'b101});
      tbl.push_back('{1'b0, 3'b011});
      tbl.push_back('{1'b0, 3'b111});
      tbl.push_back('{1'b0, 3'b110});
      tbl.push_back('{1'b0, 3'b100});
`ifdef LFSR_DEBRUIJN_EN
      tbl.push_back('{1'b0, 3'b000});
`endif
      tbl.push_back('{1'b0, 3'b001});
      tbl.push_back('{1'b1, 3'b001});
      tbl.push_back('{1'b0, 3'b010});
      tbl.push_back('{1'b0, 3'b101});
      tbl.push_back('{1'b0, 3'b011});
      tbl.push_back('{1'b0, 3'b111});
      tbl.push_back('{1'b1, 3'b001});
      tbl.push_back('{1'b0, 3'b010});

      @(negedge clk);
      foreach (tbl[i]) begin
         step(tbl[i].rst, 1'b1);
         check($sformatf("table[%0d] N3", i), dut_out[1], tbl[i].exp);
      end

      // Seed handling after a fresh reset.
      step(1'b1, 1'b1);
      check("reset N3 S1", dut_out[1], 1);
      check("reset N3 S5", dut_out[15], 5);
`ifdef LFSR_DEBRUIJN_EN
      check("reset N4 S0", dut_out[16], 0);
`else
      check("reset N4 S0", dut_out[16], 1);
`endif
      check("reset N4 SA5", dut_out[17], 5);

      // Parallel instances: distinct seeds never coincide and both wrap together.
      for (int c = 0; c < int'(period_of(3)); c++) begin
         step(1'b0, 1'b1);
         check($sformatf("parallel differ c%0d", c), 32'(dut_out[1] != dut_out[15]), 1);
      end
      check("parallel wrap S1", dut_out[1], 1);
      check("parallel wrap S5", dut_out[15], 5);

      // Random reset pulses against the model.
      for (int c = 0; c < 400; c++) begin
         step(($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0, 1'b1);
      end

      // Full-period sweep for every width.
      step(1'b1, 1'b0);
      for (int w = 0; w < 15; w++) begin
         start_v[w] = dut_out[w];
         seen[w][dut_out[w]] = 1'b1;
         distinct[w] = 1;
         zeros[w] = (dut_out[w] == 0) ? 1 : 0;
         first_ret[w] = 0;
      end
      for (int c = 1; c <= int'(period_of(16)); c++) begin
         step(1'b0, 1'b0);
         for (int w = 0; w < 15; w++) begin
            if (c <= int'(period_of(w + 2))) begin
               if (first_ret[w] == 0 && dut_out[w] == start_v[w]) first_ret[w] = c;
               if (c < int'(period_of(w + 2))) begin
                  if (!seen[w][dut_out[w]]) begin
                     seen[w][dut_out[w]] = 1'b1;
                     distinct[w]++;
                  end
                  if (dut_out[w] == 0) zeros[w]++;
               end
            end
         end
      end
      for (int w = 0; w < 15; w++) begin
         check($sformatf("period start N=%0d", w + 2), start_v[w], 1);
         check($sformatf("period return N=%0d", w + 2), first_ret[w], period_of(w + 2));
         check($sformatf("distinct N=%0d", w + 2), distinct[w], period_of(w + 2));
`ifdef LFSR_DEBRUIJN_EN
         check($sformatf("zero count N=%0d", w + 2), zeros[w], 1);
`else
         check($sformatf("zero count N=%0d", w + 2), zeros[w], 0);
`endif
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/lfsr.md
Name: lfsr

Overview:
- Free-running Fibonacci linear-feedback shift register that produces a pseudo-random N-bit word every clock.
- Game logic such as the obstacle generator uses it as a cheap randomness source for positions and types, typically taking a 2-bit slice of a 3-bit instance.
- No enable and no handshake: the register advances on every clock edge when not in reset.

Parameters:
- N, 3, register and output width; legal range 2..16. Any other value is an elaboration error raised with $error.
- SEED, 1, reset load value; only the low N bits are used.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- out  output  N  current LFSR state, driven directly from the state register.

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - While reset is high at a rising clk edge, state loads SEED[N-1:0].
  - Exception: if SEED[N-1:0] is zero and the de Bruijn mode is off, state loads 1.
  - So after reset, out = 1 with default parameters.
- Reset asserted mid-sequence reloads the seed on that same edge; the sequence position is discarded.
- Advance: on each rising edge with reset low, next = {state[N-2:0], fb}, i.e. shift left by one with fb entering at bit 0.
- Feedback: fb = XOR of state[t-1] over every tap t of width N.
- Latency: out is the register itself, so a new value appears one edge after the previous one. No combinational path from inputs to out.
- Taps (1-indexed, maximal-length):
  - 2:2,1  3:3,2  4:4,3  5:5,3  6:6,5  7:7,6  8:8,6,5,4
  - 9:9,5  10:10,7  11:11,9  12:12,6,4,1  13:13,4,3,1  14:14,5,3,1
  - 15:15,14  16:16,15,13,4
- Period: 2^N-1. The all-zero state is never entered from any reachable state.
- Lock-up: if state is ever zero (only possible by design error or an X-free force) and de Bruijn mode is off, next state = 1. This keeps the generator running.
- Reference sequence, N=3, SEED=1: 001,010,101,011,111,110,100, then 001 again.
- Instances that share reset and SEED produce identical sequences. Integrators needing independent streams must use distinct SEED values.
- Power-up without reset: state is X until the first reset edge. No initial value is required.

Optional Feature:
- Macro: LFSR_DEBRUIJN_EN.
- When defined:
  - fb is additionally XORed with (state[N-2:0] == 0), which inserts the all-zero state and makes the period exactly 2^N.
  - A SEED of zero is loaded as-is.
  - The lock-up recovery rule is removed, because zero is a normal state.
  - N=3, SEED=1 sequence: 001,010,101,011,111,110,100,000,001.
- When undefined: standard 2^N-1 behaviour as described above.

Test Plan:
- Reset load: N=3, hold reset 2 cycles -> out=001 on each edge; release -> out = 010, 101, 011, 111, 110, 100, 001 on successive edges.
- Mid-run reset: N=3, run 4 cycles (out=111), pulse reset for 1 cycle -> out=001 on that edge, then 010 next.
- Maximal period, N=2..16: run 2^N-1 cycles from reset -> no value repeats before the cycle count, out never 0, and it returns to SEED exactly at 2^N-1.
- Seed handling: N=4, SEED=0 -> out=0001 after reset. N=4, SEED=8'hA5 -> out=0101 (low bits only).
- De Bruijn build: with LFSR_DEBRUIJN_EN, N=3, SEED=1 -> 000 appears once after 100, and the period is 8. N=5 -> all 32 values each appear once per 32 cycles.
- Parallel instances: two N=3 instances with SEED=1 and SEED=5 sharing reset -> outputs differ on every cycle of one period, and both have period 7.
